reloj_hms: RTL and testbench

//   Time-of-day counter (HH:MM:SS, BCD) fed by the 1 Hz square wave from the frequency divider.

---
 rtl/reloj_hms_if.sv | 25 ++
 rtl/reloj_hms.sv | 126 ++++++++++++
 tb/tb_reloj_hms.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reloj_hms_if.sv
// rtl/reloj_hms_if.sv - control inputs and BCD time outputs of the HH:MM:SS clock
interface reloj_hms_if;
  logic       segundero;
  logic       ajustar;
  logic       inc_min;
  logic       inc_hora;
  logic [3:0] seg_u;
  logic [3:0] seg_d;
  logic [3:0] min_u;
  logic [3:0] min_d;
  logic [3:0] hora_u;
  logic [3:0] hora_d;
  logic       pulso_seg;
  logic       pulso_dia;

  modport master (
    output segundero, ajustar, inc_min, inc_hora,
    input  seg_u, seg_d, min_u, min_d, hora_u, hora_d, pulso_seg, pulso_dia
  );

  modport slave (
    input  segundero, ajustar, inc_min, inc_hora,
    output seg_u, seg_d, min_u, min_d, hora_u, hora_d, pulso_seg, pulso_dia
  );
endinterface

// File: rtl/reloj_hms.sv
// rtl/reloj_hms.sv - BCD time-of-day counter driven by the 1 Hz divider output
// Rising edges are registered as events and applied one cycle later, so ajustar is sampled with the event.
module reloj_hms #(
  parameter int HORA_MAX = 23
) (
  input  logic       reloj,
  input  logic       reset_n,
  reloj_hms_if.slave bus
);
  localparam logic [3:0] HMAX_D = 4'(HORA_MAX / 10);
  localparam logic [3:0] HMAX_U = 4'(HORA_MAX % 10);

  logic       seg_q, min_q, hora_q;
  logic       ev_seg, ev_min, ev_hora;
  logic [3:0] su, sd, mu, md, hu, hd;
  logic [3:0] su_n, sd_n, mu_n, md_n, hu_n, hd_n;
  logic [3:0] su_i, sd_i, mu_i, md_i, hu_i, hd_i;
  logic       s_wrap, m_wrap, h_wrap;
  logic       pseg, pdia, pseg_n, pdia_n;

  // Edge history resets high so a level already present at release is not an event.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      seg_q   <= 1'b1;
      min_q   <= 1'b1;
      hora_q  <= 1'b1;
      ev_seg  <= 1'b0;
      ev_min  <= 1'b0;
      ev_hora <= 1'b0;
      su      <= 4'd0;
      sd      <= 4'd0;
      mu      <= 4'd0;
      md      <= 4'd0;
      hu      <= 4'd0;
      hd      <= 4'd0;
      pseg    <= 1'b0;
      pdia    <= 1'b0;
    end else begin
      seg_q   <= bus.segundero;
      min_q   <= bus.inc_min;
      hora_q  <= bus.inc_hora;
      ev_seg  <= bus.segundero & ~seg_q;
      ev_min  <= bus.inc_min & ~min_q;
      ev_hora <= bus.inc_hora & ~hora_q;
      su      <= su_n;
      sd      <= sd_n;
      mu      <= mu_n;
      md      <= md_n;
      hu      <= hu_n;
      hd      <= hd_n;
      pseg    <= pseg_n;
      pdia    <= pdia_n;
    end
  end

  always_comb begin
    s_wrap = (su == 4'd9) && (sd == 4'd5);
    m_wrap = (mu == 4'd9) && (md == 4'd5);
    h_wrap = (hu == HMAX_U) && (hd == HMAX_D);

    su_i = (su == 4'd9) ? 4'd0 : su + 4'd1;
    sd_i = (su != 4'd9) ? sd : ((sd == 4'd5) ? 4'd0 : sd + 4'd1);
    mu_i = (mu == 4'd9) ? 4'd0 : mu + 4'd1;
    md_i = (mu != 4'd9) ? md : ((md == 4'd5) ? 4'd0 : md + 4'd1);

    if (h_wrap) begin
      hu_i = 4'd0;
      hd_i = 4'd0;
    end else if (hu == 4'd9) begin
      hu_i = 4'd0;
      hd_i = hd + 4'd1;
    end else begin
      hu_i = hu + 4'd1;
      hd_i = hd;
    end
  end

  always_comb begin
    su_n   = su;
    sd_n   = sd;
    mu_n   = mu;
    md_n   = md;
    hu_n   = hu;
    hd_n   = hd;
    pseg_n = 1'b0;
    pdia_n = 1'b0;

    if (!bus.ajustar) begin
      if (ev_seg) begin
        pseg_n = 1'b1;
        su_n   = su_i;
        sd_n   = sd_i;
        if (s_wrap) begin
          mu_n = mu_i;
          md_n = md_i;
          if (m_wrap) begin
            hu_n   = hu_i;
            hd_n   = hd_i;
            pdia_n = h_wrap;
          end
        end
      end
    end else begin
      // Set mode: minute and hour edges act independently and may land in the same cycle.
      if (ev_min) begin
        su_n = 4'd0;
        sd_n = 4'd0;
        mu_n = mu_i;
        md_n = md_i;
      end
      if (ev_hora) begin
        hu_n = hu_i;
        hd_n = hd_i;
      end
    end
  end

  assign bus.seg_u     = su;
  assign bus.seg_d     = sd;
  assign bus.min_u     = mu;
  assign bus.min_d     = md;
  assign bus.hora_u    = hu;
  assign bus.hora_d    = hd;
  assign bus.pulso_seg = pseg;
  assign bus.pulso_dia = pdia;
endmodule

// File: tb/tb_reloj_hms.sv
// tb/tb_reloj_hms.sv - scoreboard bench for reloj_hms, 24 h and 12 h builds driven in parallel
module tb_reloj_hms;
  logic reloj = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 reloj = ~reloj;
  always @(posedge reloj) cyc <= cyc + 1;

  reloj_hms_if ifc();
  reloj_hms_if ifc12();

  assign ifc12.segundero = ifc.segundero;
  assign ifc12.ajustar   = ifc.ajustar;
  assign ifc12.inc_min   = ifc.inc_min;
  assign ifc12.inc_hora  = ifc.inc_hora;

  reloj_hms #(.HORA_MAX(23)) u_dut (.reloj(reloj), .reset_n(reset_n), .bus(ifc.slave));
  reloj_hms #(.HORA_MAX(11)) u_dut12 (.reloj(reloj), .reset_n(reset_n), .bus(ifc12.slave));

  typedef struct {
    int          due;
    logic [23:0] d0;
    logic [23:0] d1;
    logic [1:0]  p0;
    logic [1:0]  p1;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference model: plain hours/minutes/seconds per build.
  int hmax [2] = '{23, 11};
  int hh [2];
  int mm [2];
  int ss [2];

  function automatic logic [23:0] digits(int i);
    return {4'(hh[i] / 10), 4'(hh[i] % 10), 4'(mm[i] / 10), 4'(mm[i] % 10),
            4'(ss[i] / 10), 4'(ss[i] % 10)};
  endfunction

  function automatic logic [1:0] step(int i, bit s, bit m, bit h, bit aj);
    int t;
    logic [1:0] p;
    p = 2'b00;
    if (!aj) begin
      if (s) begin
        t = (hh[i] * 3600 + mm[i] * 60 + ss[i] + 1) % ((hmax[i] + 1) * 3600);
        hh[i] = t / 3600;
        mm[i] = (t / 60) % 60;
        ss[i] = t % 60;
        p = {1'b1, t == 0};
      end
    end else begin
      if (m) begin
        mm[i] = (mm[i] + 1) % 60;
        ss[i] = 0;
      end
      if (h) hh[i] = (hh[i] + 1) % (hmax[i] + 1);
    end
    return p;
  endfunction

  function automatic void chk(string name, logic [25:0] act, logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      hh[i] = 0;
      mm[i] = 0;
      ss[i] = 0;
    end
  endfunction

  // Monitor: compares outputs when a queued expectation falls due; otherwise no pulse is allowed.
  always @(negedge reloj) begin
    if (reset_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_entry: due cycle %0d, now %0d", q[0].due, cyc);
        q.delete(0);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        chk("dut23_state", {ifc.pulso_seg, ifc.pulso_dia, ifc.hora_d, ifc.hora_u, ifc.min_d,
            ifc.min_u, ifc.seg_d, ifc.seg_u}, {mon_e.p0, mon_e.d0});
        chk("dut11_state", {ifc12.pulso_seg, ifc12.pulso_dia, ifc12.hora_d, ifc12.hora_u,
            ifc12.min_d, ifc12.min_u, ifc12.seg_d, ifc12.seg_u}, {mon_e.p1, mon_e.d1});
      end else if (ifc.pulso_seg || ifc.pulso_dia || ifc12.pulso_seg || ifc12.pulso_dia) begin
        chk("spurious_pulse", {22'd0, ifc.pulso_seg, ifc.pulso_dia, ifc12.pulso_seg,
            ifc12.pulso_dia}, 26'd0);
      end
    end
  end

  task automatic ev(bit s, bit m, bit h, int hold);
    exp_t e;
    @(negedge reloj);
    ifc.segundero = s;
    ifc.inc_min   = m;
    ifc.inc_hora  = h;
    e.p0  = step(0, s, m, h, ifc.ajustar);
    e.d0  = digits(0);
    e.p1  = step(1, s, m, h, ifc.ajustar);
    e.d1  = digits(1);
    e.due = cyc + 2;
    q.push_back(e);
    repeat (hold) @(negedge reloj);
    ifc.segundero = 1'b0;
    ifc.inc_min   = 1'b0;
    ifc.inc_hora  = 1'b0;
  endtask

  task automatic hold_check(int n);
    exp_t e;
    e.p0  = 2'b00;
    e.d0  = digits(0);
    e.p1  = 2'b00;
    e.d1  = digits(1);
    e.due = cyc + 2;
    q.push_back(e);
    repeat (n) @(negedge reloj);
  endtask

  task automatic set_aj(bit v);
    repeat (2) @(negedge reloj);
    ifc.ajustar = v;
    @(negedge reloj);
  endtask

  // Reset lands between edges; outputs must clear before any further clock edge.
  task automatic do_reset(bit hold_seg);
    repeat (3) @(negedge reloj);
    ifc.segundero = hold_seg;
    ifc.inc_min   = 1'b0;
    ifc.inc_hora  = 1'b0;
    ifc.ajustar   = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_dut23", {ifc.pulso_seg, ifc.pulso_dia, ifc.hora_d, ifc.hora_u, ifc.min_d,
        ifc.min_u, ifc.seg_d, ifc.seg_u}, 26'd0);
    chk("reset_dut11", {ifc12.pulso_seg, ifc12.pulso_dia, ifc12.hora_d, ifc12.hora_u,
        ifc12.min_d, ifc12.min_u, ifc12.seg_d, ifc12.seg_u}, 26'd0);
    q.delete();
    model_clear();
    repeat (2) @(negedge reloj);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int w;
    ifc.segundero = 1'b0;
    ifc.ajustar   = 1'b0;
    ifc.inc_min   = 1'b0;
    ifc.inc_hora  = 1'b0;
    model_clear();

    do_reset(1'b0);
    for (int i = 0; i < 60; i++) ev(1'b1, 1'b0, 1'b0, 1);

    do_reset(1'b0);
    set_aj(1'b1);
    for (int i = 0; i < 23; i++) ev(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 59; i++) ev(1'b0, 1'b1, 1'b0, 1);
    set_aj(1'b0);
    for (int i = 0; i < 60; i++) ev(1'b1, 1'b0, 1'b0, 1);

    do_reset(1'b0);
    for (int i = 0; i < 42; i++) ev(1'b1, 1'b0, 1'b0, 1);
    set_aj(1'b1);
    for (int i = 0; i < 3; i++) ev(1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 5; i++) ev(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 56; i++) ev(1'b0, 1'b1, 1'b0, 1);
    set_aj(1'b0);
    for (int i = 0; i < 7; i++) ev(1'b1, 1'b0, 1'b0, 1);
    set_aj(1'b1);
    ev(1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 24; i++) ev(1'b0, 1'b0, 1'b1, 1);
    ev(1'b0, 1'b1, 1'b1, 2);

    do_reset(1'b1);
    hold_check(3);
    ifc.segundero = 1'b0;
    ev(1'b1, 1'b0, 1'b0, 1);
    set_aj(1'b1);
    for (int i = 0; i < 12; i++) ev(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 34; i++) ev(1'b0, 1'b1, 1'b0, 1);
    set_aj(1'b0);
    for (int i = 0; i < 56; i++) ev(1'b1, 1'b0, 1'b0, 1);
    do_reset(1'b0);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) set_aj(~ifc.ajustar);
      else if (r == 1) repeat ($urandom_range(1, 3)) @(negedge reloj);
      else ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 3)));
    end

    w = 0;
    while (q.size() != 0 && w < 20) begin
      @(negedge reloj);
      w++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
